// File: rtl/mul_bw_arbiter.sv
// Round-robin arbiter sharing one 9x9 signed Baugh-Wooley multiplier among N_REQ requesters,
// with per-requester precision/approximation masks and a 2-stage valid/ready pipeline.

// Baugh-Wooley array: appr_mask[k]=0 drops all partial products of column k (low columns only),
// res_mask gates the upper N_BIT_RES product bits; all-ones masks give the exact product.
module mul_signed_bw #(
    parameter int MAC_IN_WIDTH  = 9,
    parameter int MAC_OUT_WIDTH = 18,
    parameter int N_BIT_RES     = 14,
    parameter int N_BIT_APPR    = 8
) (
    input  logic [MAC_IN_WIDTH-1:0]  a_i,
    input  logic [MAC_IN_WIDTH-1:0]  b_i,
    input  logic [N_BIT_RES-1:0]     res_mask_i,
    input  logic [N_BIT_APPR-1:0]    appr_mask_i,
    output logic [MAC_OUT_WIDTH-1:0] p_o
);
    localparam int W  = MAC_IN_WIDTH;
    localparam int OW = MAC_OUT_WIDTH;

    logic [OW-1:0] col_en;
    logic [OW-1:0] acc;
    logic          pp;

    always_comb begin
        col_en                 = '1;
        col_en[N_BIT_APPR-1:0] = appr_mask_i;
        acc                    = '0;
        pp                     = 1'b0;
        for (int i = 0; i < W; i++) begin
            for (int j = 0; j < W; j++) begin
                pp = a_i[i] & b_i[j];
                // mixed sign/magnitude terms are complemented; the constants below restore the sum
                if ((i == W-1) != (j == W-1)) pp = ~pp;
                pp  = pp & col_en[i+j];
                acc = acc + (OW'(pp) << (i+j));
            end
        end
        acc = acc + (OW'(1) << W) + (OW'(1) << (2*W-1));
        p_o = acc & {res_mask_i, {(OW-N_BIT_RES){1'b1}}};
    end
endmodule

module mul_bw_arbiter #(
    parameter int N_REQ         = 4,
    parameter int MAC_IN_WIDTH  = 9,
    parameter int MAC_OUT_WIDTH = 18,
    parameter int N_BIT_RES     = 14,
    parameter int N_BIT_APPR    = 8,
    parameter int TAG_W         = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [N_REQ-1:0]              req_valid,
    output logic [N_REQ-1:0]              req_ready,
    input  logic [N_REQ*MAC_IN_WIDTH-1:0] req_a,
    input  logic [N_REQ*MAC_IN_WIDTH-1:0] req_b,
    input  logic [N_REQ*TAG_W-1:0]        req_tag,
    input  logic                          cfg_we,
    input  logic [$clog2(N_REQ)-1:0]      cfg_id,
    input  logic [N_BIT_RES-1:0]          cfg_res_mask,
    input  logic [N_BIT_APPR-1:0]         cfg_appr_mask,
    output logic                          resp_valid,
    input  logic                          resp_ready,
    output logic [MAC_OUT_WIDTH-1:0]      resp_data,
    output logic [$clog2(N_REQ)-1:0]      resp_id,
    output logic [TAG_W-1:0]              resp_tag,
    output logic                          busy
);
    localparam int ID_W = $clog2(N_REQ);
    localparam int W    = MAC_IN_WIDTH;

    logic [N_BIT_RES-1:0]  cfg_res_q  [N_REQ];
    logic [N_BIT_APPR-1:0] cfg_appr_q [N_REQ];

    logic [ID_W-1:0] last_q, last_d;
    logic [ID_W-1:0] cand;
    logic [ID_W-1:0] grant_id;
    logic            grant_found;
    logic            s1_adv, s1_can_accept, handshake;

    logic                  s1_v_q, s1_v_d;
    logic [W-1:0]          s1_a_q, s1_a_d, s1_b_q, s1_b_d;
    logic [TAG_W-1:0]      s1_tag_q, s1_tag_d;
    logic [ID_W-1:0]       s1_id_q, s1_id_d;
    logic [N_BIT_RES-1:0]  s1_res_q, s1_res_d;
    logic [N_BIT_APPR-1:0] s1_appr_q, s1_appr_d;

    logic                     s2_v_q, s2_v_d;
    logic [MAC_OUT_WIDTH-1:0] s2_data_q, s2_data_d;
    logic [ID_W-1:0]          s2_id_q, s2_id_d;
    logic [TAG_W-1:0]         s2_tag_q, s2_tag_d;

    logic [MAC_OUT_WIDTH-1:0] mul_p;

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < N_REQ; i++) begin
                cfg_res_q[i]  <= '1;
                cfg_appr_q[i] <= '1;
            end
        end else if (cfg_we) begin
            cfg_res_q[cfg_id]  <= cfg_res_mask;
            cfg_appr_q[cfg_id] <= cfg_appr_mask;
        end
    end

    // search starts just after the last winner; N_REQ is a power of two so the add wraps
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        cand        = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = last_q + ID_W'(k);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_id    = cand;
            end
        end
    end

    assign s1_adv        = ~s2_v_q | resp_ready;
    assign s1_can_accept = ~s1_v_q | s1_adv;
    assign handshake     = grant_found & s1_can_accept;
    assign req_ready     = handshake ? (N_REQ'(1) << grant_id) : '0;

    mul_signed_bw #(
        .MAC_IN_WIDTH (MAC_IN_WIDTH),
        .MAC_OUT_WIDTH(MAC_OUT_WIDTH),
        .N_BIT_RES    (N_BIT_RES),
        .N_BIT_APPR   (N_BIT_APPR)
    ) u_mul (
        .a_i        (s1_a_q),
        .b_i        (s1_b_q),
        .res_mask_i (s1_res_q),
        .appr_mask_i(s1_appr_q),
        .p_o        (mul_p)
    );

    always_comb begin
        last_d    = last_q;
        s1_v_d    = s1_v_q;
        s1_a_d    = s1_a_q;
        s1_b_d    = s1_b_q;
        s1_tag_d  = s1_tag_q;
        s1_id_d   = s1_id_q;
        s1_res_d  = s1_res_q;
        s1_appr_d = s1_appr_q;
        s2_v_d    = s2_v_q;
        s2_data_d = s2_data_q;
        s2_id_d   = s2_id_q;
        s2_tag_d  = s2_tag_q;

        if (s1_adv) begin
            s1_v_d = 1'b0;
            s2_v_d = s1_v_q;
            if (s1_v_q) begin
                s2_data_d = mul_p;
                s2_id_d   = s1_id_q;
                s2_tag_d  = s1_tag_q;
            end
        end

        // masks are read before any same-edge config write lands
        if (handshake) begin
            last_d    = grant_id;
            s1_v_d    = 1'b1;
            s1_a_d    = req_a[int'(grant_id)*W +: W];
            s1_b_d    = req_b[int'(grant_id)*W +: W];
            s1_tag_d  = req_tag[int'(grant_id)*TAG_W +: TAG_W];
            s1_id_d   = grant_id;
            s1_res_d  = cfg_res_q[grant_id];
            s1_appr_d = cfg_appr_q[grant_id];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            last_q    <= ID_W'(N_REQ-1);
            s1_v_q    <= 1'b0;
            s1_a_q    <= '0;
            s1_b_q    <= '0;
            s1_tag_q  <= '0;
            s1_id_q   <= '0;
            s1_res_q  <= '1;
            s1_appr_q <= '1;
            s2_v_q    <= 1'b0;
            s2_data_q <= '0;
            s2_id_q   <= '0;
            s2_tag_q  <= '0;
        end else begin
            last_q    <= last_d;
            s1_v_q    <= s1_v_d;
            s1_a_q    <= s1_a_d;
            s1_b_q    <= s1_b_d;
            s1_tag_q  <= s1_tag_d;
            s1_id_q   <= s1_id_d;
            s1_res_q  <= s1_res_d;
            s1_appr_q <= s1_appr_d;
            s2_v_q    <= s2_v_d;
            s2_data_q <= s2_data_d;
            s2_id_q   <= s2_id_d;
            s2_tag_q  <= s2_tag_d;
        end
    end

    assign resp_valid = s2_v_q;
    assign resp_data  = s2_data_q;
    assign resp_id    = s2_id_q;
    assign resp_tag   = s2_tag_q;
    assign busy       = s1_v_q | s2_v_q;
endmodule
